// File: rtl/mem_init_loader_pkg.sv
// Shared definitions for the program-memory init loader: default geometry
// and FSM state encodings.
package mem_init_loader_pkg;

  localparam int AW_DEF    = 7;
  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    COPY   = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/mem_init_loader_init_edge_detect.sv
// Rising-edge detector for the init request, sampled on the falling clock edge
// so it lines up with the processor's timing.
module init_edge_detect (
  input  logic clock,
  input  logic resetn,
  input  logic init,
  output logic start
);

  logic init_q;

  always_ff @(negedge clock or negedge resetn) begin
    if (!resetn) init_q <= 1'b0;
    else         init_q <= init;
  end

  assign start = init & ~init_q;

endmodule

// File: rtl/mem_init_loader.sv
// Copies a program image from a synchronous ROM into the processor RAM on an
// init request, holding init_busy high and accumulating a checksum of the image.
module mem_init_loader
  import mem_init_loader_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          init,
  input  logic [DW-1:0] rom_q,
  output logic [AW-1:0] rom_address,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  output logic          init_busy,
  output logic          init_done,
  output logic [DW-1:0] checksum
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] wr_addr;
  logic          start;

  function automatic logic [DW-1:0] csum_add(input logic [DW-1:0] acc,
                                             input logic [DW-1:0] word);
    return acc + word;
  endfunction

  init_edge_detect u_edge (
    .clock  (clock),
    .resetn (resetn),
    .init   (init),
    .start  (start)
  );

  // The write address is kept separately from the ROM address because the ROM
  // address saturates at DEPTH-1 while the write side still needs that last slot.
  always_ff @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      wr_addr     <= '0;
      rom_address <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      init_busy   <= 1'b0;
      init_done   <= 1'b0;
      checksum    <= '0;
    end else begin
      case (state)
        IDLE: begin
          ram_wren    <= 1'b0;
          rom_address <= '0;
          if (start) begin
            state     <= PRIME;
            wr_addr   <= '0;
            init_busy <= 1'b1;
            init_done <= 1'b0;
            checksum  <= '0;
          end
        end
        PRIME: begin
          ram_wren <= 1'b0;
          if (rom_address < LAST) rom_address <= rom_address + 1'b1;
          state <= COPY;
        end
        COPY: begin
          ram_wren    <= 1'b1;
          ram_data    <= rom_q;
          ram_address <= wr_addr;
          checksum    <= csum_add(checksum, rom_q);
          if (rom_address < LAST) rom_address <= rom_address + 1'b1;
          if (wr_addr == LAST) state <= FINISH;
          else                 wr_addr <= wr_addr + 1'b1;
        end
        FINISH: begin
          ram_wren  <= 1'b0;
          init_busy <= 1'b0;
          init_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_init_loader.sv
// Scoreboard bench for mem_init_loader: main 128-word instance plus a DEPTH=1 build.
module tb_mem_init_loader;

  localparam int AW    = 7;
  localparam int DW    = 16;
  localparam int DEPTH = 128;

  logic          clock = 1'b0;
  logic          resetn;
  logic          init;
  logic          init1;
  logic [DW-1:0] rom_q, rom_q1;
  logic [AW-1:0] rom_address, ram_address, rom_address1, ram_address1;
  logic [DW-1:0] ram_data, ram_data1, checksum, checksum1;
  logic          ram_wren, init_busy, init_done;
  logic          ram_wren1, init_busy1, init_done1;

  logic [DW-1:0]    rom [DEPTH];
  logic [AW+DW-1:0] sb[$];
  logic [AW+DW-1:0] sb1[$];

  int n_tests  = 0;
  int n_fail   = 0;
  int wr_seen  = 0;
  int wr_seen1 = 0;

  always #5 clock = ~clock;

  mem_init_loader #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_dut (
    .clock       (clock),
    .resetn      (resetn),
    .init        (init),
    .rom_q       (rom_q),
    .rom_address (rom_address),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .init_busy   (init_busy),
    .init_done   (init_done),
    .checksum    (checksum)
  );

  mem_init_loader #(.AW(AW), .DW(DW), .DEPTH(1)) u_dut1 (
    .clock       (clock),
    .resetn      (resetn),
    .init        (init1),
    .rom_q       (rom_q1),
    .rom_address (rom_address1),
    .ram_address (ram_address1),
    .ram_data    (ram_data1),
    .ram_wren    (ram_wren1),
    .init_busy   (init_busy1),
    .init_done   (init_done1),
    .checksum    (checksum1)
  );

  // Synchronous ROMs, registered on the same falling edge as the DUT
  initial forever begin
    @(negedge clock);
    rom_q  <= rom[rom_address];
    rom_q1 <= rom[rom_address1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Write monitors: every RAM write is popped from the scoreboard and compared
  initial begin
    logic [AW+DW-1:0] exp_w;
    forever begin
      @(posedge clock);
      if (ram_wren !== 1'b0) begin
        wr_seen++;
        check("wren_inside_busy", 32'(init_busy), 32'd1);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected no write", ram_address, ram_data);
        end else begin
          exp_w = sb.pop_front();
          check("write_addr_data", 32'({ram_address, ram_data}), 32'(exp_w));
        end
      end
    end
  end

  initial begin
    logic [AW+DW-1:0] exp_w;
    forever begin
      @(posedge clock);
      if (ram_wren1 !== 1'b0) begin
        wr_seen1++;
        if (sb1.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write_d1: addr %0h data %0h, expected no write", ram_address1, ram_data1);
        end else begin
          exp_w = sb1.pop_front();
          check("write_addr_data_d1", 32'({ram_address1, ram_data1}), 32'(exp_w));
        end
      end
    end
  end

  task automatic fill_rom(input int mode);
    for (int k = 0; k < DEPTH; k++)
      rom[k] = (mode == 0) ? DW'(k + 'h100) : 16'hFFFF;
  endtask

  task automatic push_image();
    for (int k = 0; k < DEPTH; k++) sb.push_back({AW'(k), rom[k]});
  endtask

  // One full load; 'held' keeps init high and adds a retrigger pulse mid-load
  task automatic run_load(input string tag, input bit held, input logic [DW-1:0] exp_csum);
    int first_wr;
    int busy_cyc;
    int wr0;
    push_image();
    wr0      = wr_seen;
    first_wr = 0;
    busy_cyc = 0;
    @(posedge clock);
    init = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clock);
      if (cyc == 1) begin
        check({tag, "_busy_at_start"}, 32'(init_busy), 32'd1);
        check({tag, "_done_cleared"}, 32'(init_done), 32'd0);
        check({tag, "_csum_cleared"}, 32'(checksum), 32'd0);
      end
      if (!held && cyc == 2) init = 1'b0;
      if (held && cyc == 40) init = 1'b0;
      if (held && cyc == 45) init = 1'b1;
      if (ram_wren === 1'b1 && first_wr == 0) first_wr = cyc;
      if (init_busy === 1'b1) busy_cyc++;
      else break;
    end
    init = 1'b0;
    check({tag, "_first_write_cycle"}, 32'(first_wr), 32'd3);
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd130);
    check({tag, "_write_count"}, 32'(wr_seen - wr0), 32'd128);
    check({tag, "_done"}, 32'(init_done), 32'd1);
    check({tag, "_checksum"}, 32'(checksum), 32'(exp_csum));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    repeat (5) @(posedge clock);
    check({tag, "_idle_busy"}, 32'(init_busy), 32'd0);
    check({tag, "_idle_done_kept"}, 32'(init_done), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int busy_cyc;
    int first_wr;
    init   = 1'b0;
    init1  = 1'b0;
    resetn = 1'b0;
    fill_rom(0);

    // Reset and idle
    repeat (2) @(posedge clock);
    check("rst_rom_address", 32'(rom_address), 32'd0);
    check("rst_busy", 32'(init_busy), 32'd0);
    resetn = 1'b1;
    repeat (10) @(posedge clock);
    check("idle_rom_address", 32'(rom_address), 32'd0);
    check("idle_ram_address", 32'(ram_address), 32'd0);
    check("idle_ram_data", 32'(ram_data), 32'd0);
    check("idle_wren", 32'(ram_wren), 32'd0);
    check("idle_busy", 32'(init_busy), 32'd0);
    check("idle_done", 32'(init_done), 32'd0);
    check("idle_checksum", 32'(checksum), 32'd0);
    check("idle_writes", 32'(wr_seen), 32'd0);

    // Full load, then held init with a retrigger attempt while busy
    run_load("full", 1'b0, 16'h9FC0);
    run_load("held", 1'b1, 16'h9FC0);

    // Reset part-way through a load
    push_image();
    wr0 = wr_seen;
    @(posedge clock);
    init = 1'b1;
    @(posedge clock);
    init = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      if (wr_seen - wr0 >= 50) break;
    end
    check("midload_reached_50", 32'(wr_seen - wr0 >= 50), 32'd1);
    #1 resetn = 1'b0;
    sb.delete();
    #1;
    check("midload_rst_wren", 32'(ram_wren), 32'd0);
    check("midload_rst_busy", 32'(init_busy), 32'd0);
    check("midload_rst_done", 32'(init_done), 32'd0);
    check("midload_rst_checksum", 32'(checksum), 32'd0);
    check("midload_rst_rom_address", 32'(rom_address), 32'd0);
    repeat (3) @(posedge clock);
    resetn = 1'b1;
    repeat (6) @(posedge clock);
    check("post_rst_busy", 32'(init_busy), 32'd0);
    check("post_rst_done", 32'(init_done), 32'd0);
    run_load("after_reset", 1'b0, 16'h9FC0);

    // All-ones image wraps the checksum
    fill_rom(1);
    run_load("wrap", 1'b0, 16'hFF80);

    // Single-word build
    fill_rom(0);
    sb1.push_back({AW'(0), 16'h0100});
    wr0      = wr_seen1;
    busy_cyc = 0;
    first_wr = 0;
    @(posedge clock);
    init1 = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clock);
      if (cyc == 2) init1 = 1'b0;
      if (ram_wren1 === 1'b1 && first_wr == 0) first_wr = cyc;
      if (init_busy1 === 1'b1) busy_cyc++;
      else break;
    end
    init1 = 1'b0;
    check("d1_first_write_cycle", 32'(first_wr), 32'd3);
    check("d1_busy_cycles", 32'(busy_cyc), 32'd3);
    check("d1_write_count", 32'(wr_seen1 - wr0), 32'd1);
    check("d1_done", 32'(init_done1), 32'd1);
    check("d1_checksum", 32'(checksum1), 32'h0100);
    check("d1_sb_empty", 32'(sb1.size()), 32'd0);
    repeat (4) @(posedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
